mru_lookup_sched: RTL and testbench
===================================

# mru_lookup_sched

Round-robin scheduler that shares one 4-entry most-recent-unique-value tracker among NUM_REQ requesters. Each accepted request is serialized onto the tracker's single data input. The scheduler snapshots the tracker contents before the update to report hit/position, then checks the post-update head entry. It also owns the tracker's reset line, so a flush can be sequenced safely between operations.

## Interface
- DATA_W, 8: data width; must equal the tracker's data width.
- NUM_REQ, 4: number of requesters, 2..8.
- clk_in  in  1  single clock, rising edge.
- reset_in  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_W  per-requester value; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant. Request i is accepted when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NUM_REQ)  index of the granted requester.
- rsp_data  out  DATA_W  value that was looked up.
- rsp_hit  out  1  value was present in a valid tracker entry before the update.
- rsp_pos  out  2  matching entry index on a hit; 0 on a miss.
- rsp_err  out  1  after the update, tracker entry 0 did not hold rsp_data with valid set.
- flush_in  in  1  single-cycle flush request pulse.
- busy  out  1  high whenever the FSM is not in IDLE.
- trk_reset  out  1  tracker reset; equals reset_in OR (state==FLUSH).
- trk_data  out  DATA_W  registered tracker data input.
- trk_out_0..3  in  DATA_W each  tracker entries.
- trk_valid_0..3  in  1 each  tracker entry valid bits.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CHECK, RESP, FLUSH.
- IDLE
  - If a flush is pending, go to FLUSH. Flush has priority over requests.
  - Otherwise, if any req_valid is high, grant one requester round-robin:
    - Search starts at rr_ptr and wraps modulo NUM_REQ.
    - req_ready is combinational and one-hot, asserted only in IDLE.
    - On grant: register id and data, load trk_data with the value, set rr_ptr = granted+1 mod NUM_REQ, go to ISSUE.
- ISSUE
  - Compare the captured value against trk_out_k where trk_valid_k==1.
  - Register hit and the lowest matching index k as pos.
  - Go to WAIT.
- WAIT: one cycle for the tracker's internal delay. Go to CHECK.
- CHECK
  - Register err = !(trk_valid_0 && trk_out_0==data).
  - Go to RESP.
- RESP
  - Hold rsp_valid=1 and all rsp_* fields stable until rsp_ready=1.
  - After the handshake, go to IDLE.
- FLUSH
  - One cycle: trk_reset=1 and trk_data=0.
  - Clear the pending-flush flag, go to IDLE.
- Flush latching
  - flush_in is latched into pending_flush in any state.
  - A pulse while busy is served after the current response handshake.
  - Multiple pulses before service merge into one flush.
- trk_data holds the last issued value while idle. Re-presenting the head value leaves the tracker unchanged.
- rsp_data/rsp_id/rsp_hit/rsp_pos/rsp_err are don't-care when rsp_valid=0; they are held from the last response.
- Reset values
  - state=IDLE, rr_ptr=0, pending_flush=0.
  - trk_data=0, rsp_valid=0, rsp_hit=0, rsp_pos=0, rsp_err=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready=0 during reset.

## Timing
- Acceptance edge is cycle 0. ISSUE is cycle 1, WAIT cycle 2, CHECK cycle 3.
- rsp_valid is first high in cycle 4.
- Earliest next grant is the cycle after the rsp handshake. Peak throughput is 1 request per 5 cycles.
- Tracker timing: trk_data registered at cycle 0 enters the tracker's delay stage at the end of cycle 1; the entries update at the end of cycle 2. The cycle-1 snapshot therefore sees the pre-update state, and the cycle-3 check sees the post-update state.
- Flush: trk_reset is high for exactly one cycle, the cycle after IDLE sees pending_flush.
- reset_in mid-operation
  - Aborts the operation. Any in-flight response is lost.
  - trk_reset follows reset_in in the same cycle.
- Simultaneous flush_in and request in IDLE: the flush wins; the request waits (req_ready=0).
- Value 0 right after reset or flush: tracker entry 0 already holds 0 with valid clear, so nothing is inserted. Required response is rsp_hit=0, rsp_err=1. This is the specified behaviour, not a scheduler fault.

## Test plan
- Reset, then requester 2 sends 0x5A. Required: req_ready=0b0100 in the accept cycle; rsp_valid rises 4 cycles later with rsp_id=2, rsp_data=0x5A, rsp_hit=0, rsp_pos=0, rsp_err=0.
- Send 0x11, 0x22, 0x33 in sequence, then 0x11. Required for the last: rsp_hit=1, rsp_pos=2, rsp_err=0.
- All four requesters valid continuously, rsp_ready=1. Required grant order: 0,1,2,3,0,…; back-to-back grants 5 cycles apart.
- Hold rsp_ready=0 for 10 cycles during RESP. Required: fields stable, no req_ready asserted; the next grant occurs in the cycle after the handshake.
- Pulse flush_in during WAIT. Required: the response completes normally, then one trk_reset cycle; a following lookup of a previously cached value returns rsp_hit=0.
- After reset, send 0x00. Required: rsp_hit=0, rsp_err=1. Also assert reset_in in WAIT: required that rsp_valid never rises and busy=0 on the next cycle.

Source files
------------

// File: rtl/mru_lookup_sched_if.sv
// Requester and response bundle shared by the scheduler and its clients.
interface mru_lookup_sched_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_hit;
  logic [1:0]                rsp_pos;
  logic                      rsp_err;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit, rsp_pos, rsp_err
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_hit, rsp_pos, rsp_err
  );
endinterface

// File: rtl/mru_lookup_sched.sv
// Round-robin scheduler serializing lookups onto a shared 4-entry MRU tracker,
// reporting pre-update hit/position and a post-update head check, and
// sequencing tracker flushes between operations.
module mru_lookup_sched #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  mru_lookup_sched_if.slave bus,
  input  logic              flush_in,
  output logic              busy,
  output logic              trk_reset,
  output logic [DATA_W-1:0] trk_data,
  input  logic [DATA_W-1:0] trk_out_0,
  input  logic [DATA_W-1:0] trk_out_1,
  input  logic [DATA_W-1:0] trk_out_2,
  input  logic [DATA_W-1:0] trk_out_3,
  input  logic              trk_valid_0,
  input  logic              trk_valid_1,
  input  logic              trk_valid_2,
  input  logic              trk_valid_3
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_RESP,
    S_FLUSH
  } state_t;

  state_t state, state_next;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_found;
  logic [DATA_W-1:0]  grant_data;
  logic               accept;
  logic               flush_go;
  logic               pending_flush;
  logic [NUM_REQ-1:0] ready;

  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  data_q;
  logic               hit_q;
  logic [1:0]         pos_q;
  logic               match_hit;
  logic [1:0]         match_pos;

  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_hit_q;
  logic [1:0]         rsp_pos_q;
  logic               rsp_err_q;

  assign flush_go   = flush_in | pending_flush;
  assign grant_data = bus.req_data[grant_id*DATA_W +: DATA_W];
  assign trk_reset  = reset_in | (state == S_FLUSH);

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_pos   = rsp_pos_q;
  assign bus.rsp_err   = rsp_err_q;

  // Round-robin search for the first valid requester starting at rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && bus.req_valid[ID_W'((32'(rr_ptr) + i) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // Lowest valid tracker entry matching the captured value (pre-update snapshot)
  always_comb begin
    match_hit = 1'b0;
    match_pos = 2'd0;
    if (trk_valid_3 && trk_out_3 == data_q) begin match_hit = 1'b1; match_pos = 2'd3; end
    if (trk_valid_2 && trk_out_2 == data_q) begin match_hit = 1'b1; match_pos = 2'd2; end
    if (trk_valid_1 && trk_out_1 == data_q) begin match_hit = 1'b1; match_pos = 2'd1; end
    if (trk_valid_0 && trk_out_0 == data_q) begin match_hit = 1'b1; match_pos = 2'd0; end
  end

  // Next-state and grant decode; flush outranks any request in IDLE
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ready      = '0;
    case (state)
      S_IDLE: begin
        if (flush_go) begin
          state_next = S_FLUSH;
        end else if (grant_found) begin
          accept     = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  state_next = S_CHECK;
      S_CHECK: state_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
      S_FLUSH: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (accept && !reset_in) ready[grant_id] = 1'b1;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) state <= S_IDLE;
    else          state <= state_next;
  end

  // Capture, lookup result, response and flush bookkeeping
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rr_ptr        <= '0;
      pending_flush <= 1'b0;
      busy          <= 1'b0;
      trk_data      <= '0;
      id_q          <= '0;
      data_q        <= '0;
      hit_q         <= 1'b0;
      pos_q         <= 2'd0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_pos_q     <= 2'd0;
      rsp_err_q     <= 1'b0;
    end else begin
      busy          <= (state_next != S_IDLE);
      pending_flush <= (state == S_FLUSH) ? flush_in : (pending_flush | flush_in);
      case (state)
        S_IDLE: begin
          if (flush_go) begin
            trk_data <= '0;
          end else if (accept) begin
            id_q     <= grant_id;
            data_q   <= grant_data;
            trk_data <= grant_data;
            rr_ptr   <= ID_W'((32'(grant_id) + 1) % NUM_REQ);
          end
        end
        S_ISSUE: begin
          hit_q <= match_hit;
          pos_q <= match_pos;
        end
        S_CHECK: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_data_q  <= data_q;
          rsp_hit_q   <= hit_q;
          rsp_pos_q   <= pos_q;
          rsp_err_q   <= !(trk_valid_0 && trk_out_0 == data_q);
        end
        S_RESP: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mru_lookup_sched.sv
// Self-checking bench: cycle-level tracker emulation plus a queue-based MRU
// reference model for expected responses.
module tb_mru_lookup_sched;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic flush_in = 1'b0;
  logic busy, trk_reset;
  logic [DATA_W-1:0] trk_data;
  logic [DATA_W-1:0] ent0, ent1, ent2, ent3;
  logic [3:0]        vld;

  int errors = 0;
  int checks = 0;
  int exp_rr = 0;
  logic [7:0] mru_q[$];

  mru_lookup_sched_if #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) bus ();

  mru_lookup_sched #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
    .clk_in(clk), .reset_in(reset_in), .bus(bus), .flush_in(flush_in),
    .busy(busy), .trk_reset(trk_reset), .trk_data(trk_data),
    .trk_out_0(ent0), .trk_out_1(ent1), .trk_out_2(ent2), .trk_out_3(ent3),
    .trk_valid_0(vld[0]), .trk_valid_1(vld[1]), .trk_valid_2(vld[2]), .trk_valid_3(vld[3])
  );

  always #5 clk = ~clk;

  // Tracker emulation: one delay stage, then move-to-front / insert at head
  logic [7:0] stage;
  always @(posedge clk) begin
    int k;
    if (trk_reset) begin
      stage <= 8'h00; vld <= 4'h0;
      ent0 <= 8'h00; ent1 <= 8'h00; ent2 <= 8'h00; ent3 <= 8'h00;
    end else begin
      stage <= trk_data;
      if (stage != ent0) begin
        k = 3;
        if (vld[3] && ent3 == stage) k = 3;
        if (vld[2] && ent2 == stage) k = 2;
        if (vld[1] && ent1 == stage) k = 1;
        ent0 <= stage; vld[0] <= 1'b1;
        ent1 <= ent0;  vld[1] <= vld[0];
        if (k >= 2) begin ent2 <= ent1; vld[2] <= vld[1]; end
        if (k >= 3) begin ent3 <= ent2; vld[3] <= vld[2]; end
      end
    end
  end

  // Reference: list of valid values, most recent first
  function automatic void model_lookup(input logic [7:0] v, output logic hit,
                                       output logic [1:0] pos, output logic err);
    int idx = -1;
    foreach (mru_q[i]) if (idx < 0 && mru_q[i] == v) idx = i;
    hit = (idx >= 0);
    pos = hit ? 2'(idx) : 2'd0;
    if (idx >= 0) mru_q.delete(idx);
    if (!(v == 8'h00 && mru_q.size() == 0 && idx < 0)) mru_q.push_front(v);
    if (mru_q.size() > 4) void'(mru_q.pop_back());
    err = !(mru_q.size() > 0 && mru_q[0] == v);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one request to completion; lat = -1 if grant or response never came
  task automatic lookup(input int id, input logic [7:0] v, output int lat,
                        output logic [ID_W-1:0] rid, output logic [7:0] rdata,
                        output logic rhit, output logic [1:0] rpos, output logic rerr);
    int n;
    lat = -1; rid = '0; rdata = '0; rhit = 1'b0; rpos = 2'd0; rerr = 1'b0;
    bus.req_valid = '0;
    bus.req_valid[2'(id)] = 1'b1;
    bus.req_data[5'(id*8) +: 8] = v;
    #1;
    n = 0;
    while (bus.req_ready[2'(id)] !== 1'b1 && n < 40) begin tick(); n++; end
    if (bus.req_ready[2'(id)] !== 1'b1) begin bus.req_valid = '0; return; end
    tick();
    bus.req_valid = '0;
    exp_rr = (id + 1) % NUM_REQ;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    if (bus.rsp_valid !== 1'b1) return;
    lat = n; rid = bus.rsp_id; rdata = bus.rsp_data;
    rhit = bus.rsp_hit; rpos = bus.rsp_pos; rerr = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    bus.req_valid = '1;
    tick(); tick();
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (trk_reset !== 1'b1) begin errors++; $display("FAIL reset_trk_reset got=%b exp=1", trk_reset); end
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_busy_valid got=%b%b exp=00", busy, bus.rsp_valid); end
    checks++; if (trk_data !== 8'h00 || bus.rsp_data !== 8'h00 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_data got=%h/%h/%0d exp=0", trk_data, bus.rsp_data, bus.rsp_id); end
    checks++; if (bus.rsp_hit !== 1'b0 || bus.rsp_pos !== 2'd0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b/%0d/%b exp=0", bus.rsp_hit, bus.rsp_pos, bus.rsp_err); end
    bus.req_valid = '0;
    reset_in = 1'b0;
    mru_q.delete(); exp_rr = 0;
    tick();
    checks++; if (trk_reset !== 1'b0) begin errors++; $display("FAIL reset_release_trk got=%b exp=0", trk_reset); end
  endtask

  task automatic test_first_lookup();
    int lat; logic [ID_W-1:0] rid; logic [7:0] rd; logic rh, re, eh, ee; logic [1:0] rp, ep;
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'h5A;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL first_grant got=%b exp=0100", bus.req_ready); end
    lookup(2, 8'h5A, lat, rid, rd, rh, rp, re);
    model_lookup(8'h5A, eh, ep, ee);
    checks++; if (lat !== 4) begin errors++; $display("FAIL first_latency got=%0d exp=4", lat); end
    checks++; if (rid !== 2'd2 || rd !== 8'h5A) begin errors++; $display("FAIL first_id_data got=%0d/%h exp=2/5a", rid, rd); end
    checks++; if (rh !== 1'b0 || rp !== 2'd0 || re !== 1'b0) begin errors++; $display("FAIL first_flags got=%b/%0d/%b exp=0/0/0", rh, rp, re); end
  endtask

  task automatic test_hit_position();
    int lat; logic [ID_W-1:0] rid; logic [7:0] rd; logic rh, re, eh, ee; logic [1:0] rp, ep;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h11};
    int ids [4] = '{0, 1, 3, 2};
    for (int i = 0; i < 4; i++) begin
      lookup(ids[i], vals[i], lat, rid, rd, rh, rp, re);
      model_lookup(vals[i], eh, ep, ee);
      checks++; if (lat !== 4 || rd !== vals[i] || rid !== 2'(ids[i])) begin errors++; $display("FAIL seq_rsp[%0d] got=lat%0d/%h/%0d exp=lat4/%h/%0d", i, lat, rd, rid, vals[i], ids[i]); end
      checks++; if (rh !== eh || rp !== ep || re !== ee) begin errors++; $display("FAIL seq_flags[%0d] got=%b/%0d/%b exp=%b/%0d/%b", i, rh, rp, re, eh, ep, ee); end
    end
    checks++; if (rh !== 1'b1 || rp !== 2'd2 || re !== 1'b0) begin errors++; $display("FAIL seq_last got=%b/%0d/%b exp=1/2/0", rh, rp, re); end
  endtask

  task automatic test_round_robin();
    int grants = 0, prev_cyc = 0, refresh = -1, gid;
    logic eh, ee; logic [1:0] ep;
    int q_id[$]; logic [7:0] q_d[$]; logic q_h[$]; logic [1:0] q_p[$]; logic q_e[$];
    for (int k = 0; k < 4; k++) bus.req_data[5'(k*8) +: 8] = 8'($urandom_range(1, 6));
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 80 && (grants < 8 || q_id.size() > 0); cyc++) begin
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (q_id.size() == 0) begin
          errors++; $display("FAIL rr_unexpected_rsp got=valid exp=idle");
        end else begin
          if (bus.rsp_id !== 2'(q_id[0]) || bus.rsp_data !== q_d[0] || bus.rsp_hit !== q_h[0] ||
              bus.rsp_pos !== q_p[0] || bus.rsp_err !== q_e[0]) begin
            errors++;
            $display("FAIL rr_rsp got=%0d/%h/%b/%0d/%b exp=%0d/%h/%b/%0d/%b", bus.rsp_id, bus.rsp_data,
                     bus.rsp_hit, bus.rsp_pos, bus.rsp_err, q_id[0], q_d[0], q_h[0], q_p[0], q_e[0]);
          end
          void'(q_id.pop_front()); void'(q_d.pop_front()); void'(q_h.pop_front());
          void'(q_p.pop_front()); void'(q_e.pop_front());
        end
      end
      if (bus.req_ready !== 4'b0000 && grants < 8) begin
        checks++; if (bus.req_ready !== 4'(1 << exp_rr)) begin errors++; $display("FAIL rr_order got=%b exp=%b", bus.req_ready, 4'(1 << exp_rr)); end
        if (grants > 0) begin
          checks++; if (cyc - prev_cyc !== 5) begin errors++; $display("FAIL rr_spacing got=%0d exp=5", cyc - prev_cyc); end
        end
        gid = 0;
        for (int k = 0; k < 4; k++) if (bus.req_ready[2'(k)]) gid = k;
        model_lookup(bus.req_data[5'(gid*8) +: 8], eh, ep, ee);
        q_id.push_back(gid); q_d.push_back(bus.req_data[5'(gid*8) +: 8]);
        q_h.push_back(eh); q_p.push_back(ep); q_e.push_back(ee);
        exp_rr = (gid + 1) % NUM_REQ;
        prev_cyc = cyc; refresh = gid; grants++;
      end
      tick();
      if (refresh >= 0) begin bus.req_data[5'(refresh*8) +: 8] = 8'($urandom_range(1, 6)); refresh = -1; end
      if (grants >= 8) bus.req_valid = '0;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    checks++; if (grants !== 8 || q_id.size() !== 0) begin errors++; $display("FAIL rr_complete got=%0d grants/%0d pending exp=8/0", grants, q_id.size()); end
  endtask

  task automatic test_backpressure();
    int id, other, n; logic [7:0] v, v2; logic eh, ee; logic [1:0] ep;
    id = int'($urandom_range(0, 3)); other = (id + 1) % NUM_REQ;
    v = 8'($urandom_range(1, 6)); v2 = 8'($urandom_range(1, 6));
    bus.req_data[5'(id*8) +: 8] = v;
    bus.req_data[5'(other*8) +: 8] = v2;
    bus.req_valid = '0; bus.req_valid[2'(id)] = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready[2'(id)] !== 1'b1 && n < 40) begin tick(); n++; end
    model_lookup(v, eh, ep, ee);
    tick();
    bus.req_valid = '0; bus.req_valid[2'(other)] = 1'b1;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(id) || bus.rsp_data !== v || bus.rsp_hit !== eh ||
          bus.rsp_pos !== ep || bus.rsp_err !== ee || bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d] got=%b/%0d/%h/%b/%0d/%b rdy=%b exp=1/%0d/%h/%b/%0d/%b rdy=0000", i, bus.rsp_valid,
                 bus.rsp_id, bus.rsp_data, bus.rsp_hit, bus.rsp_pos, bus.rsp_err, bus.req_ready, id, v, eh, ep, ee);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.req_ready !== 4'(1 << other)) begin errors++; $display("FAIL bp_next_grant got=%b exp=%b", bus.req_ready, 4'(1 << other)); end
    model_lookup(v2, eh, ep, ee);
    exp_rr = (other + 1) % NUM_REQ;
    tick();
    bus.req_valid = '0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (bus.rsp_data !== v2 || bus.rsp_hit !== eh || bus.rsp_pos !== ep || bus.rsp_err !== ee) begin errors++; $display("FAIL bp_second got=%h/%b/%0d/%b exp=%h/%b/%0d/%b", bus.rsp_data, bus.rsp_hit, bus.rsp_pos, bus.rsp_err, v2, eh, ep, ee); end
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
  endtask

  task automatic test_flush();
    int lat, n; logic [ID_W-1:0] rid; logic [7:0] rd; logic rh, re, eh, ee; logic [1:0] rp, ep;
    lookup(0, 8'hA1, lat, rid, rd, rh, rp, re);
    model_lookup(8'hA1, eh, ep, ee);
    checks++; if (lat !== 4 || rh !== eh || re !== ee) begin errors++; $display("FAIL flush_pre got=lat%0d/%b/%b exp=lat4/%b/%b", lat, rh, re, eh, ee); end
    bus.req_valid = 4'b0010; bus.req_data[15:8] = 8'hB2;
    #1;
    n = 0;
    while (bus.req_ready[1] !== 1'b1 && n < 40) begin tick(); n++; end
    model_lookup(8'hB2, eh, ep, ee);
    exp_rr = 2;
    tick(); bus.req_valid = '0;
    tick();
    flush_in = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_wait got=%b exp=1", busy); end
    tick();
    flush_in = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hB2 || bus.rsp_hit !== eh || bus.rsp_err !== ee || trk_reset !== 1'b0) begin errors++; $display("FAIL flush_rsp got=%b/%h/%b/%b trk=%b exp=1/b2/%b/%b trk=0", bus.rsp_valid, bus.rsp_data, bus.rsp_hit, bus.rsp_err, trk_reset, eh, ee); end
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100; bus.req_data[23:16] = 8'hA1;
    #1;
    checks++; if (trk_reset !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL flush_idle got=trk%b/busy%b/rdy%b exp=0/0/0000", trk_reset, busy, bus.req_ready); end
    tick();
    checks++; if (trk_reset !== 1'b1 || trk_data !== 8'h00 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL flush_cycle got=trk%b/%h/rdy%b exp=1/00/0000", trk_reset, trk_data, bus.req_ready); end
    mru_q.delete();
    tick();
    checks++; if (trk_reset !== 1'b0) begin errors++; $display("FAIL flush_single got=%b exp=0", trk_reset); end
    lookup(2, 8'hA1, lat, rid, rd, rh, rp, re);
    model_lookup(8'hA1, eh, ep, ee);
    checks++; if (lat !== 4 || rh !== 1'b0 || rp !== 2'd0 || re !== 1'b0) begin errors++; $display("FAIL flush_after got=lat%0d/%b/%0d/%b exp=lat4/0/0/0", lat, rh, rp, re); end
  endtask

  task automatic test_random();
    int lat, id; logic [ID_W-1:0] rid; logic [7:0] rd, v; logic rh, re, eh, ee; logic [1:0] rp, ep;
    for (int i = 0; i < 30; i++) begin
      id = int'($urandom_range(0, 3));
      v  = 8'($urandom_range(0, 6));
      lookup(id, v, lat, rid, rd, rh, rp, re);
      model_lookup(v, eh, ep, ee);
      checks++; if (lat !== 4 || rid !== 2'(id) || rd !== v) begin errors++; $display("FAIL rand_rsp[%0d] got=lat%0d/%0d/%h exp=lat4/%0d/%h", i, lat, rid, rd, id, v); end
      checks++; if (rh !== eh || rp !== ep || re !== ee) begin errors++; $display("FAIL rand_flags[%0d] got=%b/%0d/%b exp=%b/%0d/%b", i, rh, rp, re, eh, ep, ee); end
    end
  endtask

  task automatic test_zero_and_abort();
    int lat, n, seen; logic [ID_W-1:0] rid; logic [7:0] rd; logic rh, re; logic [1:0] rp;
    reset_in = 1'b1; tick(); tick(); reset_in = 1'b0;
    mru_q.delete(); exp_rr = 0;
    lookup(1, 8'h00, lat, rid, rd, rh, rp, re);
    checks++; if (lat !== 4 || rid !== 2'd1 || rd !== 8'h00) begin errors++; $display("FAIL zero_rsp got=lat%0d/%0d/%h exp=lat4/1/00", lat, rid, rd); end
    checks++; if (rh !== 1'b0 || rp !== 2'd0 || re !== 1'b1) begin errors++; $display("FAIL zero_flags got=%b/%0d/%b exp=0/0/1", rh, rp, re); end
    bus.req_valid = 4'b1000; bus.req_data[31:24] = 8'h77;
    #1;
    n = 0;
    while (bus.req_ready[3] !== 1'b1 && n < 40) begin tick(); n++; end
    tick(); bus.req_valid = '0;
    tick();
    reset_in = 1'b1;
    #1;
    checks++; if (trk_reset !== 1'b1) begin errors++; $display("FAIL abort_trk_reset got=%b exp=1", trk_reset); end
    tick();
    reset_in = 1'b0;
    mru_q.delete(); exp_rr = 0;
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_state got=busy%b/valid%b exp=0/0", busy, bus.rsp_valid); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp got=%0d exp=0", seen); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_first_lookup();
    test_hit_position();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_random();
    test_zero_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
